// File: rtl/ntlm_block_builder_pkg.sv
// rtl/ntlm_block_builder_pkg.sv - shared constants, state encoding and byte-slice helper
//
// Purpose: definitions shared by the NTLM block builder.
//   NTLM_MAX_LEN  longest password (chars) whose UTF-16LE form plus the 0x80
//                 pad byte still fits ahead of the length field (2*27+1 <= 56).
//   MD4_IV_*      MD4 chaining initial values, for tying off md4block state_a..d.
//   state_e       builder FSM states.
//   byte_msb()    MSB bit position of message byte k inside the 512-bit block
//                 (byte 0 occupies bits [511:504]).
package ntlm_block_builder_pkg;

  localparam int NTLM_MAX_LEN = 27;

  localparam logic [31:0] MD4_IV_A = 32'h67452301;
  localparam logic [31:0] MD4_IV_B = 32'hEFCDAB89;
  localparam logic [31:0] MD4_IV_C = 32'h98BADCFE;
  localparam logic [31:0] MD4_IV_D = 32'h10325476;

  typedef enum logic [2:0] {
    ST_CLEAR   = 3'd0,
    ST_ACCEPT  = 3'd1,
    ST_FINAL   = 3'd2,
    ST_ISSUE   = 3'd3,
    ST_WAIT_HI = 3'd4,
    ST_WAIT_LO = 3'd5
  } state_e;

  function automatic logic [8:0] byte_msb(input logic [5:0] idx);
    return 9'd511 - {idx, 3'b000};
  endfunction

endpackage

// File: rtl/ntlm_block_builder.sv
// rtl/ntlm_block_builder.sv - ASCII password to padded UTF-16LE MD4 block feeder
//
// Purpose: collects one password per in_last-terminated beat stream, widens
// each char to UTF-16LE, appends MD4 padding and the bit length, then starts
// md4block and holds the block until md4block has finished.
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   in_valid/ready  beat handshake (ready only while collecting)
//   in_char         ASCII character of the beat
//   in_nochar       beat carries no character (empty password with in_last)
//   in_last         final beat of the password
//   md4_irdy        one-cycle start pulse to md4block
//   md4_data        512-bit message block, byte k at [511-8k -: 8]
//   md4_ordy        md4block done indication
//   busy            high whenever not collecting a password
//   err_len         one-cycle pulse: over-long password discarded
module ntlm_block_builder
  import ntlm_block_builder_pkg::*;
#(
  parameter int MAX_LEN = NTLM_MAX_LEN
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_char,
  input  logic         in_nochar,
  input  logic         in_last,
  output logic         md4_irdy,
  output logic [511:0] md4_data,
  input  logic         md4_ordy,
  output logic         busy,
  output logic         err_len
);

  localparam logic [4:0] MAX_LEN_C = 5'(MAX_LEN);

  state_e       state_q, state_d;
  logic [4:0]   count_q, count_d;
  logic         ovf_q, ovf_d;
  logic         err_q, err_d;
  logic [511:0] data_q, data_d;

  logic         ovf_set;
  logic [15:0]  bit_len;

  // Message length in bits: 2 bytes per char, 8 bits per byte.
  assign bit_len = {7'd0, count_q, 4'd0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_ACCEPT;
      count_q <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    err_d   = 1'b0;
    data_d  = data_q;
    ovf_set = 1'b0;

    case (state_q)
      ST_CLEAR: begin
        data_d  = '0;
        count_d = '0;
        ovf_d   = 1'b0;
        state_d = ST_ACCEPT;
      end

      ST_ACCEPT: begin
        if (in_valid) begin
          if (!in_nochar) begin
            // Once full, further chars only mark the password as too long;
            // the high byte of each UTF-16 unit is already zero from CLEAR.
            if (ovf_q || (count_q == MAX_LEN_C)) begin
              ovf_set = 1'b1;
            end else begin
              data_d[byte_msb({count_q, 1'b0}) -: 8] = in_char;
              count_d = count_q + 5'd1;
            end
          end
          ovf_d = ovf_q | ovf_set;
          if (in_last) begin
            if (ovf_q || ovf_set) begin
              err_d   = 1'b1;
              state_d = ST_CLEAR;
            end else begin
              state_d = ST_FINAL;
            end
          end
        end
      end

      ST_FINAL: begin
        data_d[byte_msb({count_q, 1'b0}) -: 8] = 8'h80;
        // Bytes 56 and 57 hold the little-endian bit length.
        data_d[63:48] = {bit_len[7:0], bit_len[15:8]};
        state_d = ST_ISSUE;
      end

      ST_ISSUE: state_d = ST_WAIT_HI;

      ST_WAIT_HI: if (md4_ordy) state_d = ST_WAIT_LO;

      // md4block returns to idle once ordy drops, so the block may now change.
      ST_WAIT_LO: if (!md4_ordy) state_d = ST_CLEAR;

      default: state_d = ST_CLEAR;
    endcase
  end

  assign in_ready = (state_q == ST_ACCEPT) && !rst;
  assign md4_irdy = (state_q == ST_ISSUE);
  assign busy     = (state_q != ST_ACCEPT);
  assign err_len  = err_q;
  assign md4_data = data_q;

endmodule
